// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the ALU execute stage: FSM encoding, opcode values, flag bit positions.
package alu_exec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [7:0] OP_ADD = 8'h00;
  localparam logic [7:0] OP_SUB = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h02;
  localparam logic [7:0] OP_DIV = 8'h03;
  localparam logic [7:0] OP_MOD = 8'h13;

  localparam int FLAG_SIGN = 2;
  localparam int FLAG_PAR  = 3;
  localparam int FLAG_DZ   = 4;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the execute stage: two combinational read ports, one write port, r0 hardwired to zero.
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(NREGS)-1:0] raddr1,
  input  logic [$clog2(NREGS)-1:0] raddr2,
  output logic [W-1:0]             rdata1,
  output logic [W-1:0]             rdata2
);

  logic [W-1:0] mem [NREGS];

  // NOTE: storage is cleared by reset here because the architecture requires every register to read 0
  // after rst; memories without that requirement are normally left unreset so they map to RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage controller feeding an external combinational ALU: IDLE -> EXEC -> WB handshake FSM.
// Optional divide-by-zero trap enabled by defining ALU_EXEC_DIVZERO_TRAP_EN.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_op,
  input  logic [2:0]   in_rd,
  input  logic [2:0]   in_rs1,
  input  logic [2:0]   in_rs2,
  input  logic [W-1:0] in_imm,
  input  logic         in_use_imm,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [7:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic [7:0]   alu_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   out_rd,
  output logic [W-1:0] out_data,
  output logic [7:0]   flags_q
);

  state_t       state_q, state_d;
  logic [7:0]   op_q;
  logic [2:0]   rd_q;
  logic [W-1:0] a_q, b_q, out_data_q;
  logic [W-1:0] rs1_data, rs2_data;
  logic         accept, exec_done, div_zero, rf_we;
  logic         unused_alu_flags;

  assign unused_alu_flags = ^alu_flags[7:4];

`ifdef ALU_EXEC_DIVZERO_TRAP_EN
  assign div_zero = is_div_op(op_q) && (b_q == '0);
`else
  assign div_zero = 1'b0;
`endif

  // A trapped division leaves the destination register untouched.
  assign rf_we = exec_done && !div_zero;

  alu_regfile #(.NREGS(NREGS), .W(W)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rd_q),
    .wdata  (alu_result),
    .raddr1 (in_rs1),
    .raddr2 (in_rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    exec_done = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        exec_done = 1'b1;
        state_d   = WB;
      end
      WB: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_data_q <= '0;
      flags_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= in_op;
        rd_q <= in_rd;
        a_q  <= rs1_data;
        b_q  <= in_use_imm ? in_imm : rs2_data;
      end
      if (exec_done) begin
        out_data_q         <= div_zero ? {W{1'b1}} : alu_result;
        flags_q            <= '0;
        flags_q[FLAG_DZ]   <= div_zero;
        flags_q[FLAG_PAR]  <= alu_flags[FLAG_PAR];
        flags_q[FLAG_SIGN] <= alu_flags[FLAG_SIGN];
        flags_q[1:0]       <= alu_flags[1:0];
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign out_rd   = rd_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage with a behavioural ALU and register-file model.
// Expectations follow ALU_EXEC_DIVZERO_TRAP_EN when the macro is defined for the build.
module tb_alu_exec_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_use_imm;
  logic [7:0] in_op, in_imm;
  logic [2:0] in_rd, in_rs1, in_rs2;
  logic [7:0] alu_a, alu_b, alu_op, alu_result, alu_flags;
  logic       out_valid, out_ready;
  logic [2:0] out_rd;
  logic [7:0] out_data, flags_q;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mregs [8];

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      8'h00:   return a + b;
      8'h01:   return a - b;
      8'h02:   return a * b;
      8'h03:   return (b == 0) ? 8'h00 : a / b;
      8'h13:   return (b == 0) ? 8'h00 : a % b;
      default: return 8'h00;
    endcase
  endfunction

  // Bits 7:4 carry junk so the stage is seen to ignore them.
  function automatic logic [7:0] ref_flags(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic carry;
    r = ref_alu(op, a, b);
    carry = 1'b0;
    if (op == 8'h00) carry = (int'(a) + int'(b)) > 255;
    if (op == 8'h01) carry = a < b;
    return {4'hA, ^r, r[7], carry, r == 8'h00};
  endfunction

  assign alu_result = ref_alu(alu_op, alu_a, alu_b);
  assign alu_flags  = ref_flags(alu_op, alu_a, alu_b);

  alu_exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .flags_q(flags_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full instruction: accept, EXEC, WB with optional stall, optional early in_valid at release.
  task automatic run_instr(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [7:0] imm, input logic use_imm,
                           input int stall, input bit early);
    logic [7:0] a, b, res, fl, exp_data;
    logic dz;
    a   = mregs[rs1];
    b   = use_imm ? imm : mregs[rs2];
    res = ref_alu(op, a, b);
    fl  = ref_flags(op, a, b);
    dz  = 1'b0;
`ifdef ALU_EXEC_DIVZERO_TRAP_EN
    dz  = ((op == 8'h03) || (op == 8'h13)) && (b == 8'h00);
`endif
    exp_data = dz ? 8'hFF : res;

    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_use_imm = use_imm;
    in_valid = 1'b1;
    check("in_ready_idle", {7'b0, in_ready}, 8'h01);
    tick();
    in_valid = 1'b0;
    in_op = 8'($urandom); in_imm = 8'($urandom); in_rs1 = 3'($urandom); in_rs2 = 3'($urandom);
    check("exec_alu_a", alu_a, a);
    check("exec_alu_b", alu_b, b);
    check("exec_alu_op", alu_op, op);
    check("exec_out_valid", {7'b0, out_valid}, 8'h00);
    tick();
    for (int c = 0; c <= stall; c++) begin
      check("wb_out_valid", {7'b0, out_valid}, 8'h01);
      check("wb_out_data", out_data, exp_data);
      check("wb_out_rd", {5'b0, out_rd}, {5'b0, rd});
      check("wb_flags", flags_q, {3'b0, dz, fl[3:0]});
      check("wb_in_ready", {7'b0, in_ready}, 8'h00);
      if (c < stall) tick();
    end
    if (early) begin
      in_valid = 1'b1; in_op = 8'h00; in_rd = 3'd0; in_rs1 = 3'd0; in_imm = 8'h00; in_use_imm = 1'b1;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (!dz && rd != 3'd0) mregs[rd] = res;
    check("post_out_valid", {7'b0, out_valid}, 8'h00);
    check("post_in_ready", {7'b0, in_ready}, 8'h01);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ops [6];
    ops[0] = 8'h00; ops[1] = 8'h01; ops[2] = 8'h02; ops[3] = 8'h03; ops[4] = 8'h13; ops[5] = 8'h00;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0; in_use_imm = 0;
    tick(); tick();
    check("rst_in_ready", {7'b0, in_ready}, 8'h01);
    check("rst_out_valid", {7'b0, out_valid}, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_rd", {5'b0, out_rd}, 8'h00);
    check("rst_flags", flags_q, 8'h00);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_op", alu_op, 8'h00);
    rst = 1'b0;

    // Directed cases.
    run_instr(8'h00, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 0, 1'b0);
    run_instr(8'h00, 3'd2, 3'd0, 3'd0, 8'h07, 1'b1, 0, 1'b0);
    run_instr(8'h01, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 0, 1'b0);
    run_instr(8'h00, 3'd0, 3'd3, 3'd0, 8'h00, 1'b1, 0, 1'b0);
    run_instr(8'h00, 3'd6, 3'd0, 3'd0, 8'h10, 1'b1, 0, 1'b0);
    run_instr(8'h03, 3'd4, 3'd6, 3'd0, 8'h00, 1'b1, 0, 1'b0);
    run_instr(8'h00, 3'd0, 3'd4, 3'd0, 8'h00, 1'b1, 0, 1'b0);
    run_instr(8'h13, 3'd5, 3'd6, 3'd0, 8'h00, 1'b1, 0, 1'b0);
    run_instr(8'h00, 3'd7, 3'd1, 3'd0, 8'h11, 1'b1, 5, 1'b1);
    run_instr(8'h00, 3'd0, 3'd0, 3'd0, 8'h33, 1'b1, 0, 1'b0);
    run_instr(8'h00, 3'd5, 3'd0, 3'd0, 8'h00, 1'b1, 0, 1'b0);
    run_instr(8'h5A, 3'd2, 3'd1, 3'd3, 8'h00, 1'b0, 0, 1'b0);

    // Randomized instructions.
    for (int n = 0; n < 40; n++) begin
      ops[5] = 8'($urandom);
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom), 3'($urandom), 3'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'($urandom),
                $urandom_range(0, 2), 1'($urandom));
    end

    // Reset arriving during EXEC discards the result and clears the register file.
    in_op = 8'h00; in_rd = 3'd1; in_rs1 = 3'd2; in_rs2 = 3'd3; in_use_imm = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    check("rstx_out_valid", {7'b0, out_valid}, 8'h00);
    check("rstx_in_ready", {7'b0, in_ready}, 8'h01);
    check("rstx_flags", flags_q, 8'h00);
    check("rstx_alu_a", alu_a, 8'h00);
    for (int i = 1; i < 8; i++) run_instr(8'h00, 3'd0, 3'(i), 3'd0, 8'h00, 1'b1, 0, 1'b0);
    for (int i = 1; i < 8; i++) run_instr(8'h00, 3'd0, 3'd0, 3'(i), 8'h00, 1'b0, 0, 1'b0);

    // Reset outranks a simultaneous accept.
    in_op = 8'h02; in_rs1 = 3'd0; in_imm = 8'h44; in_use_imm = 1'b1; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rstpri_in_ready", {7'b0, in_ready}, 8'h01);
    check("rstpri_alu_b", alu_b, 8'h00);
    check("rstpri_alu_op", alu_op, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage controller that sits directly upstream of the combinational `alu`. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal 8×8 register file. It drives `a`/`b`/`op` into the ALU, captures `result` and `flags`, writes the result back, and presents it downstream over a second valid/ready handshake.

## Interface
Parameters:
- `NREGS`, 8: register-file depth; fixed at 8, so addresses are 3 bits.
- `W`, 8: data width; must match the ALU.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept; high only in IDLE.
- `in_op`  in  8  ALU opcode, passed unchanged to the ALU.
- `in_rd`, `in_rs1`, `in_rs2`  in  3 each  destination and source register indices.
- `in_imm`  in  8  immediate operand.
- `in_use_imm`  in  1  when 1, operand b = `in_imm` instead of reg[`in_rs2`].
- `alu_a`, `alu_b`  out  8  operands to the ALU.
- `alu_op`  out  8  opcode to the ALU.
- `alu_result`  in  8  ALU result.
- `alu_flags`  in  8  ALU flags.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts the result.
- `out_rd`  out  3  destination index of the result.
- `out_data`  out  8  result value.
- `flags_q`  out  8  architectural flag register.

## Operation
State machine `IDLE` → `EXEC` → `WB` → `IDLE`.
- IDLE:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, latch op, rd, a=reg[rs1], b=(use_imm ? imm : reg[rs2]), then go to EXEC.
- EXEC:
  - `alu_a`/`alu_b`/`alu_op` are driven from the latched operands. They are driven from these registers in all states, so they are stable whenever the stage is in EXEC.
  - At the end of the EXEC cycle:
    - capture `alu_result` into `out_data`;
    - set `flags_q[3:0]` = `alu_flags[3:0]` (bit 3 parity, bit 2 sign, bits 1:0 as produced by the ALU);
    - write reg[rd] = `alu_result`;
    - go to WB.
- WB:
  - `out_valid`=1; `out_data`, `out_rd` and `flags_q` stay stable.
  - On `out_ready`, go to IDLE.
- Register 0 reads as 0x00 and ignores writes.
- The register file has no other write path.
- `flags_q[7:5]` are always 0.
- Opcodes not decoded by the ALU yield result 0x00 and are treated normally; the stage does not decode opcodes except as described in Configuration.
- Reset values:
  - state IDLE;
  - `in_ready`=1 (reset-held IDLE);
  - `out_valid`=0, `out_data`=0, `out_rd`=0, `flags_q`=0;
  - all registers 0;
  - latched operands and op 0, so `alu_a`=`alu_b`=`alu_op`=0.

## Timing
- Accept at edge N. EXEC occupies cycle N+1. `out_valid` rises after edge N+1.
- Minimum of 3 cycles per instruction. The next accept can occur in the cycle after the output handshake.
- A register written by instruction k is visible to instruction k+1's operand read; no forwarding is needed.
- Backpressure: while `out_ready`=0 in WB, the stage holds indefinitely and `in_ready`=0.
- `rst` asserted in any state takes effect at the next edge: IDLE entered, the pending result is discarded, and the register file is cleared.
- `rst` has priority over every handshake in the same cycle.
- Simultaneous `out_ready` and a new `in_valid` in WB: only the output completes; the input waits one cycle.

## Configuration
- Macro `ALU_EXEC_DIVZERO_TRAP_EN`.
- Defined:
  - in EXEC, if op is 0x03 (div) or 0x13 (mod) and b==0, then `out_data`=0xFF, `flags_q[4]`=1, and reg[rd] is not written;
  - any other completed instruction clears `flags_q[4]`.
- Undefined:
  - no check; the ALU result is used and written as-is;
  - `flags_q[4]` is tied to 0.

## Structure
- Shared package `alu_exec_pkg` holds:
  - state encoding (IDLE=2'd0, EXEC=2'd1, WB=2'd2);
  - opcode constants OP_ADD 0x00, OP_SUB 0x01, OP_MUL 0x02, OP_DIV 0x03, OP_MOD 0x13;
  - flag bit indices FLAG_SIGN=2, FLAG_PAR=3, FLAG_DZ=4.
- One sub-module `alu_regfile`:
  - 8×8 storage, two combinational read ports, one synchronous write port with write-enable;
  - r0 hardwired to zero;
  - synchronous clear on `rst`.
- The `alu` instance lives in the parent, not in this block.

## Test plan
- Reset, then ADD rd=1, rs1=0, imm=0x05, use_imm → out after 2 edges: `out_data`=0x05, `out_rd`=1, `flags_q`=0x00.
- With r1=0x05, load r2=0x07 (ADD with imm), then SUB rd=3, rs1=1, rs2=2 → `out_data`=0xFE, `flags_q[2]`=1, `flags_q[3]`=1, reg3=0xFE.
- With the macro defined: DIV rd=4, a=0x10, b=imm 0x00 → `out_data`=0xFF, `flags_q[4]`=1, reg4 keeps 0x00. A following ADD clears `flags_q[4]`.
- Hold `out_ready`=0 for 5 cycles in WB → `out_valid`=1, `out_data` constant, `in_ready`=0 throughout. A subsequent `in_valid` is accepted only after the handshake.
- ADD rd=0, imm=0x33, then ADD rd=5, rs1=0, imm=0 → `out_data`=0x00 (r0 unwritable).
- Assert `rst` during EXEC → next cycle `out_valid`=0, `in_ready`=1, `flags_q`=0, and every register reads 0.
